// File: rtl/cluster_center_update.sv
// k-means centroid update: accumulates per-cluster coordinate sums and member counts,
// then divides each sum by its count with a pair of restoring dividers.
module cluster_center_update #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_CLUSTERS = 8,
  parameter int unsigned NUM_POINTS   = 128
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [WIDTH-1:0]                      points_x       [NUM_POINTS],
  input  logic [WIDTH-1:0]                      points_y       [NUM_POINTS],
  input  logic [((NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1)-1:0] assignments [NUM_POINTS],
  input  logic [WIDTH-1:0]                      prev_centers_x [NUM_CLUSTERS],
  input  logic [WIDTH-1:0]                      prev_centers_y [NUM_CLUSTERS],
  output logic [WIDTH-1:0]                      centers_x      [NUM_CLUSTERS],
  output logic [WIDTH-1:0]                      centers_y      [NUM_CLUSTERS],
  output logic [NUM_CLUSTERS-1:0]               empty_mask,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned CW    = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_POINTS + 1);
  localparam int unsigned SUM_W = WIDTH + CNT_W;
  localparam int unsigned IT_W  = $clog2(SUM_W + 1);
  localparam int unsigned PW    = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

  localparam logic [PW-1:0]   LAST_P = PW'(NUM_POINTS - 1);
  localparam logic [CW-1:0]   LAST_K = CW'(NUM_CLUSTERS - 1);
  localparam logic [IT_W-1:0] ITERS  = IT_W'(SUM_W);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DIV_LOAD, DIV_ITER, DONE} state_t;

  state_t state, state_nxt;

  logic [SUM_W-1:0] sum_x [NUM_CLUSTERS];
  logic [SUM_W-1:0] sum_y [NUM_CLUSTERS];
  logic [CNT_W-1:0] count [NUM_CLUSTERS];
  logic [PW-1:0]    p_idx;
  logic [CW-1:0]    k_idx;
  logic [IT_W-1:0]  iter;
  logic [CNT_W-1:0] rem_x, rem_y;
  logic [SUM_W-1:0] dq_x, dq_y;

  logic [CW-1:0]    a;
  logic             a_valid;
  logic             last_p, last_k, last_iter, cnt_zero;
  logic [CNT_W:0]   shift_x, shift_y, diff_x, diff_y;
  logic             ge_x, ge_y;
  logic [CNT_W-1:0] rem_x_nxt, rem_y_nxt;
  logic [SUM_W-1:0] dq_x_nxt, dq_y_nxt;

  always_comb begin
    a         = assignments[p_idx];
    a_valid   = (32'(a) < NUM_CLUSTERS);
    last_p    = (p_idx == LAST_P);
    last_k    = (k_idx == LAST_K);
    last_iter = (iter == IT_W'(1));
    cnt_zero  = (count[k_idx] == '0);
  end

  // dq holds the not-yet-consumed dividend bits above the quotient bits shifted in so far;
  // the subtraction's top bit acts as the borrow since rem < divisor always holds.
  always_comb begin
    shift_x   = {rem_x, dq_x[SUM_W-1]};
    shift_y   = {rem_y, dq_y[SUM_W-1]};
    diff_x    = shift_x - {1'b0, count[k_idx]};
    diff_y    = shift_y - {1'b0, count[k_idx]};
    ge_x      = ~diff_x[CNT_W];
    ge_y      = ~diff_y[CNT_W];
    rem_x_nxt = ge_x ? diff_x[CNT_W-1:0] : shift_x[CNT_W-1:0];
    rem_y_nxt = ge_y ? diff_y[CNT_W-1:0] : shift_y[CNT_W-1:0];
    dq_x_nxt  = {dq_x[SUM_W-2:0], ge_x};
    dq_y_nxt  = {dq_y[SUM_W-2:0], ge_y};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = CLEAR;
      CLEAR:    state_nxt = ACCUM;
      ACCUM:    if (last_p) state_nxt = DIV_LOAD;
      DIV_LOAD: begin
        if (!cnt_zero)   state_nxt = DIV_ITER;
        else if (last_k) state_nxt = DONE;
      end
      DIV_ITER: if (last_iter) state_nxt = last_k ? DONE : DIV_LOAD;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CLUSTERS; k++) begin
        sum_x[k]     <= '0;
        sum_y[k]     <= '0;
        count[k]     <= '0;
        centers_x[k] <= '0;
        centers_y[k] <= '0;
      end
      empty_mask <= '0;
      p_idx      <= '0;
      k_idx      <= '0;
      iter       <= '0;
      rem_x      <= '0;
      rem_y      <= '0;
      dq_x       <= '0;
      dq_y       <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          for (int unsigned k = 0; k < NUM_CLUSTERS; k++) begin
            sum_x[k] <= '0;
            sum_y[k] <= '0;
            count[k] <= '0;
          end
          p_idx <= '0;
          k_idx <= '0;
        end
        ACCUM: begin
          if (a_valid) begin
            sum_x[a] <= sum_x[a] + SUM_W'(points_x[p_idx]);
            sum_y[a] <= sum_y[a] + SUM_W'(points_y[p_idx]);
            count[a] <= count[a] + CNT_W'(1);
          end
          p_idx <= p_idx + PW'(1);
        end
        DIV_LOAD: begin
          if (cnt_zero) begin
            centers_x[k_idx]  <= prev_centers_x[k_idx];
            centers_y[k_idx]  <= prev_centers_y[k_idx];
            empty_mask[k_idx] <= 1'b1;
            if (!last_k) k_idx <= k_idx + CW'(1);
          end else begin
            empty_mask[k_idx] <= 1'b0;
            dq_x  <= sum_x[k_idx];
            dq_y  <= sum_y[k_idx];
            rem_x <= '0;
            rem_y <= '0;
            iter  <= ITERS;
          end
        end
        DIV_ITER: begin
          rem_x <= rem_x_nxt;
          rem_y <= rem_y_nxt;
          dq_x  <= dq_x_nxt;
          dq_y  <= dq_y_nxt;
          iter  <= iter - IT_W'(1);
          if (last_iter) begin
            centers_x[k_idx] <= dq_x_nxt[WIDTH-1:0];
            centers_y[k_idx] <= dq_y_nxt[WIDTH-1:0];
            if (!last_k) k_idx <= k_idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_center_update.sv
// Randomized scoreboard bench for cluster_center_update: a plain-arithmetic mean model
// predicts centers, empty mask and done latency for every accepted pass.
module tb_cluster_center_update;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NC    = 8;
  localparam int unsigned NP    = 128;
  localparam int unsigned SUM_W = WIDTH + $clog2(NP + 1);

  typedef struct packed {
    logic [NC-1:0][WIDTH-1:0] ex;
    logic [NC-1:0][WIDTH-1:0] ey;
    logic [NC-1:0]            mask;
    int                       lat;
    int                       s_edge;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] px [NP];
  logic [WIDTH-1:0] py [NP];
  logic [2:0]       asg [NP];
  logic [WIDTH-1:0] prev_x [NC];
  logic [WIDTH-1:0] prev_y [NC];
  logic [WIDTH-1:0] cx [NC];
  logic [WIDTH-1:0] cy [NC];
  logic [NC-1:0]    empty_mask;
  logic             busy, done;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t sb [$];

  cluster_center_update #(.WIDTH(WIDTH), .NUM_CLUSTERS(NC), .NUM_POINTS(NP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .points_x(px), .points_y(py), .assignments(asg),
    .prev_centers_x(prev_x), .prev_centers_y(prev_y),
    .centers_x(cx), .centers_y(cy), .empty_mask(empty_mask),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    longint unsigned sx [NC];
    longint unsigned sy [NC];
    int              n  [NC];
    e = '0;
    for (int k = 0; k < NC; k++) begin sx[k] = 0; sy[k] = 0; n[k] = 0; end
    for (int p = 0; p < NP; p++) begin
      sx[asg[p]] += px[p];
      sy[asg[p]] += py[p];
      n[asg[p]]++;
    end
    e.lat = 2 + NP;
    for (int k = 0; k < NC; k++) begin
      if (n[k] == 0) begin
        e.ex[k]   = prev_x[k];
        e.ey[k]   = prev_y[k];
        e.mask[k] = 1'b1;
        e.lat     += 1;
      end else begin
        e.ex[k] = WIDTH'(sx[k] / longint'(n[k]));
        e.ey[k] = WIDTH'(sy[k] / longint'(n[k]));
        e.lat   += 1 + SUM_W;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 64'(edge_cnt - e.s_edge + 1), 64'(e.lat));
        chk("empty_mask", 64'(empty_mask), 64'(e.mask));
        for (int k = 0; k < NC; k++) begin
          chk($sformatf("center_x[%0d]", k), 64'(cx[k]), 64'(e.ex[k]));
          chk($sformatf("center_y[%0d]", k), 64'(cy[k]), 64'(e.ey[k]));
        end
      end
    end
  end

  // glitch: extra start pulses during ACCUM (cycles 20, 100) and DIV (cycle 300)
  // rst_at: if nonzero, reset the pass at that cycle instead of letting it finish
  task automatic run_pass(input bit glitch, input int rst_at);
    exp_t e;
    int   i;
    bit   aborted;
    aborted = 1'b0;
    e = model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    e.s_edge = edge_cnt;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_cycle1", 64'(busy), 64'd1);
    i = 1;
    while (sb.size() != 0 && i < 2000 && !aborted) begin
      @(negedge clk);
      i++;
      start = glitch && (i == 20 || i == 100 || i == 300);
      if (rst_at != 0 && i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mask", 64'(empty_mask), 64'd0);
        for (int k = 0; k < NC; k++) begin
          chk("rst_cx", 64'(cx[k]), 64'd0);
          chk("rst_cy", 64'(cy[k]), 64'd0);
        end
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      chk("done_timeout", 64'd1, 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_prev();
    for (int k = 0; k < NC; k++) begin
      prev_x[k] = $urandom;
      prev_y[k] = $urandom;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int p = 0; p < NP; p++) begin px[p] = '0; py[p] = '0; asg[p] = '0; end
    for (int k = 0; k < NC; k++) begin prev_x[k] = '0; prev_y[k] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_mask", 64'(empty_mask), 64'd0);
    for (int k = 0; k < NC; k++) begin
      chk("reset_cx", 64'(cx[k]), 64'd0);
      chk("reset_cy", 64'(cy[k]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // uniform split
    rand_prev();
    for (int p = 0; p < NP; p++) begin px[p] = WIDTH'(p); py[p] = WIDTH'(2 * p); asg[p] = 3'(p % NC); end
    run_pass(1'b0, 0);

    // everything in cluster 3
    for (int k = 0; k < NC; k++) begin prev_x[k] = WIDTH'(k); prev_y[k] = WIDTH'(k); end
    for (int p = 0; p < NP; p++) begin px[p] = 7; py[p] = 9; asg[p] = 3'd3; end
    run_pass(1'b0, 0);

    // truncation
    rand_prev();
    for (int p = 0; p < NP; p++) begin px[p] = 0; py[p] = 0; asg[p] = 3'd0; end
    px[5] = 1; py[5] = 0; asg[5] = 3'd1;
    px[6] = 2; py[6] = 5; asg[6] = 3'd1;
    run_pass(1'b0, 0);

    // max coordinates
    for (int p = 0; p < NP; p++) begin px[p] = '1; py[p] = '1; asg[p] = 3'($urandom_range(0, NC - 1)); end
    run_pass(1'b0, 0);

    // random passes, some with sparse cluster usage
    for (int r = 0; r < 4; r++) begin
      rand_prev();
      for (int p = 0; p < NP; p++) begin
        px[p]  = $urandom;
        py[p]  = (r == 3) ? $urandom_range(0, 15) : $urandom;
        asg[p] = (r >= 2) ? 3'($urandom_range(0, 2) * 3) : 3'($urandom_range(0, NC - 1));
      end
      run_pass(1'b0, 0);
    end

    // start pulses while busy on the uniform pattern
    rand_prev();
    for (int p = 0; p < NP; p++) begin px[p] = WIDTH'(p); py[p] = WIDTH'(2 * p); asg[p] = 3'(p % NC); end
    run_pass(1'b1, 0);

    // reset during ACCUM, then a fresh random pass
    run_pass(1'b0, 50);
    repeat (5) @(negedge clk);
    for (int p = 0; p < NP; p++) begin px[p] = $urandom; py[p] = $urandom; asg[p] = 3'($urandom_range(0, NC - 1)); end
    run_pass(1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
